mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// single-port memory bus. Data wins collisions, with a bounded run so fetches cannot starve.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_valid,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);
    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        m_valid_q, m_valid_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_be_q, m_be_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant_data;
    logic        grant_instr;

    // Word alignment drops the low address bits on both ports.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // Fetch overrides data only once the data run has reached its limit.
    always_comb begin
        grant_data  = d_req && !(i_req && (starve_cnt_q == LIMIT));
        grant_instr = i_req && !grant_data;
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        m_valid_d    = m_valid_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_be_d       = m_be_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d   = BUS_D;
                    m_valid_d = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = {d_addr[31:2], 2'b00};
                    m_wdata_d = d_wdata;
                    m_be_d    = d_be;
                    if (i_req) begin
                        starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
                    end
                end else if (grant_instr) begin
                    state_d      = BUS_I;
                    m_valid_d    = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = {i_addr[31:2], 2'b00};
                    m_wdata_d    = 32'h0;
                    m_be_d       = 4'hF;
                    starve_cnt_d = 4'd0;
                end
            end
            BUS_I: begin
                if (m_valid_q && m_ready) begin
                    state_d   = RESP;
                    m_valid_d = 1'b0;
                    i_rdata_d = m_rdata;
                    i_ack_d   = 1'b1;
                end
            end
            BUS_D: begin
                if (m_valid_q && m_ready) begin
                    state_d   = RESP;
                    m_valid_d = 1'b0;
                    d_rdata_d = m_rdata;
                    d_ack_d   = 1'b1;
                end
            end
            RESP: begin
                // The ack is visible in this cycle; requests are not looked at until IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            m_valid_q    <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= 32'h0;
            m_wdata_q    <= 32'h0;
            m_be_q       <= 4'h0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            m_valid_q    <= m_valid_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_be_q       <= m_be_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_be    = m_be_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
